dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the pipeline's MEM stage and an external DMA/debug loader (program and data preload, memory dump).
- Sits between the MEM-stage control/address/write-data signals and the data memory.
- Sequences one access at a time and stalls the pipeline while the port is busy or lost to the loader.
- An optional fairness guard bounds how long the loader can be starved.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_port_arbiter_if.sv | 46 ++++
 rtl/dmem_arb_starve_ctr.sv | 32 +++
 rtl/dmem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing helpers for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic {
        PIPE,
        DMA
    } owner_t;

    // Smallest width able to hold the values 0..max_val.
    function automatic int unsigned ctr_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Pipeline, loader and memory-side signals of the data-memory port arbiter.
interface dmem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
);
    logic              p_req;
    logic              p_we;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              p_stall;
    logic              p_rvalid;
    logic [DATA_W-1:0] p_rdata;

    logic              d_valid;
    logic              d_ready;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_stall, p_rvalid, p_rdata,
        input  d_valid, d_we, d_addr, d_wdata,
        output d_ready, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_stall, p_rvalid, p_rdata,
        output d_valid, d_we, d_addr, d_wdata,
        input  d_ready, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Counts contended pipeline grants and forces a loader grant once STARVE_MAX is reached.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic Reset,
    input  logic pipe_grant,
    input  logic dma_grant,
    input  logic d_valid,
    output logic force_dma
);
    localparam int unsigned      CNT_W = ctr_w(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            starve_cnt <= '0;
        end else if (dma_grant) begin
            starve_cnt <= '0;
        end else if (pipe_grant && d_valid && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Gated by d_valid so a departed loader cannot lock the pipeline out.
    assign force_dma = (starve_cnt == CNT_MAX) && d_valid;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the MEM stage and a DMA/debug loader.
// Optional loader fairness guard: define DMEM_ARB_FAIRNESS_EN.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 CLK,
    input  logic                 Reset,
    dmem_port_arbiter_if.slave   bus
);
    localparam int unsigned      LAT_W    = ctr_w(MEM_LAT);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_bad_cfg
        $error("dmem_port_arbiter: MEM_LAT and STARVE_MAX must be at least 1");
    end

    state_t            state;
    owner_t            owner;
    logic [LAT_W-1:0]  lat_cnt;
    logic              m_en_q;
    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic              p_rvalid_q;
    logic              d_rvalid_q;

    logic grant_pipe;
    logic grant_dma;
    logic force_dma;
    logic rd_last;
    logic p_done;

`ifdef DMEM_ARB_FAIRNESS_EN
    dmem_arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_ctr (
        .CLK       (CLK),
        .Reset     (Reset),
        .pipe_grant(grant_pipe),
        .dma_grant (grant_dma),
        .d_valid   (bus.d_valid),
        .force_dma (force_dma)
    );
`else
    assign force_dma = 1'b0;
`endif

    always_comb begin
        grant_pipe = 1'b0;
        grant_dma  = 1'b0;
        if (state == IDLE) begin
            if (bus.p_req && !force_dma) begin
                grant_pipe = 1'b1;
            end else if (bus.d_valid) begin
                grant_dma = 1'b1;
            end
        end
    end

    // High when the following cycle is the read's data cycle, so rvalid can be registered.
    assign rd_last = ((state == ISSUE) && !m_we_q && (LAT_LOAD == '0)) ||
                     ((state == WAIT) && (lat_cnt == LAT_W'(1)));

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            owner      <= PIPE;
            lat_cnt    <= '0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            p_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            m_en_q     <= 1'b0;
            p_rvalid_q <= rd_last && (owner == PIPE);
            d_rvalid_q <= rd_last && (owner == DMA);
            case (state)
                IDLE: begin
                    if (grant_pipe || grant_dma) begin
                        state     <= ISSUE;
                        m_en_q    <= 1'b1;
                        owner     <= grant_pipe ? PIPE : DMA;
                        m_we_q    <= grant_pipe ? bus.p_we    : bus.d_we;
                        m_addr_q  <= grant_pipe ? bus.p_addr  : bus.d_addr;
                        m_wdata_q <= grant_pipe ? bus.p_wdata : bus.d_wdata;
                    end
                end
                ISSUE: begin
                    if (m_we_q) begin
                        state <= IDLE;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= LAT_LOAD;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign p_done = ((state == ISSUE) && (owner == PIPE) && m_we_q) || p_rvalid_q;

    assign bus.p_stall  = bus.p_req && !p_done;
    assign bus.p_rvalid = p_rvalid_q;
    assign bus.p_rdata  = p_rvalid_q ? bus.m_rdata : '0;
    assign bus.d_ready  = grant_dma;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.d_rdata  = d_rvalid_q ? bus.m_rdata : '0;
    assign bus.m_en     = m_en_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: MEM_LAT=1 and MEM_LAT=3 instances, access-timeline model plus directed literals.
module tb_dmem_port_arbiter;
    localparam int AW   = 6;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
`ifdef DMEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    typedef struct packed {
        logic          p_stall;
        logic          p_rvalid;
        logic [DW-1:0] p_rdata;
        logic          d_ready;
        logic          d_rvalid;
        logic [DW-1:0] d_rdata;
        logic          m_en;
        logic          m_we;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata;
    } obs_t;

    typedef struct packed {
        logic          p_req;
        logic          p_we;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_wdata;
        logic          d_valid;
        logic          d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
    } in_t;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT0), .STARVE_MAX(SMAX)) dut0 (
        .CLK(clk), .Reset(rst0), .bus(bus0.slave));
    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1), .STARVE_MAX(SMAX)) dut1 (
        .CLK(clk), .Reset(rst1), .bus(bus1.slave));

    function automatic logic [DW-1:0] init_word(input int k, input int i);
        if (i == 5) return 32'hDEADBEEF;
        return 32'hA500_0000 | (32'(k) << 16) | 32'(i);
    endfunction

    // Memory environment: synchronous RAM with a MEM_LAT-deep read pipeline.
    logic [DW-1:0] mem0 [64];
    logic [DW-1:0] mem1 [64];
    logic [DW-1:0] rd0, rd1a, rd1b, rd1c;

    always @(posedge clk) begin
        if (rst0) begin
            for (int i = 0; i < 64; i++) mem0[i] <= init_word(0, i);
            rd0 <= '0;
        end else begin
            if (bus0.m_en && bus0.m_we) mem0[bus0.m_addr] <= bus0.m_wdata;
            rd0 <= (bus0.m_en && !bus0.m_we) ? mem0[bus0.m_addr] : 32'hBAD0BAD0;
        end
    end

    always @(posedge clk) begin
        if (rst1) begin
            for (int i = 0; i < 64; i++) mem1[i] <= init_word(1, i);
            rd1a <= '0; rd1b <= '0; rd1c <= '0;
        end else begin
            if (bus1.m_en && bus1.m_we) mem1[bus1.m_addr] <= bus1.m_wdata;
            rd1a <= (bus1.m_en && !bus1.m_we) ? mem1[bus1.m_addr] : 32'hBAD1BAD1;
            rd1b <= rd1a;
            rd1c <= rd1b;
        end
    end

    assign bus0.m_rdata = rd0;
    assign bus1.m_rdata = rd1c;

    obs_t o0, o1;
    in_t  i0, i1;
    assign o0 = {bus0.p_stall, bus0.p_rvalid, bus0.p_rdata, bus0.d_ready, bus0.d_rvalid,
                 bus0.d_rdata, bus0.m_en, bus0.m_we, bus0.m_addr, bus0.m_wdata};
    assign o1 = {bus1.p_stall, bus1.p_rvalid, bus1.p_rdata, bus1.d_ready, bus1.d_rvalid,
                 bus1.d_rdata, bus1.m_en, bus1.m_we, bus1.m_addr, bus1.m_wdata};
    assign i0 = {bus0.p_req, bus0.p_we, bus0.p_addr, bus0.p_wdata,
                 bus0.d_valid, bus0.d_we, bus0.d_addr, bus0.d_wdata};
    assign i1 = {bus1.p_req, bus1.p_we, bus1.p_addr, bus1.p_wdata,
                 bus1.d_valid, bus1.d_we, bus1.d_addr, bus1.d_wdata};

    int checks;
    int errors;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: an access is a timeline counted from its grant cycle (t=0).
    // m_en at t=1; a write ends at t=1; a read returns data at t=MEM_LAT+1 and then ends.
    int            t        [2] = '{-1, -1};
    bit            own_dma  [2];
    bit            rwe      [2];
    logic [AW-1:0] raddr    [2];
    logic [DW-1:0] rwdata   [2];
    logic [DW-1:0] rexp     [2];
    int            starve   [2];
    int            dma_grants  [2] = '{0, 0};
    int            pipe_grants [2] = '{0, 0};
    logic [DW-1:0] smem     [2][64];

    task automatic model_step(input int k, input int lat, input logic rst, input in_t in, input obs_t o);
        bit gp, gd, frc, rd_done, pdone, e_stall, e_prv, e_drv, e_rdy, e_men;
        string n;
        n = (k == 0) ? "lat1" : "lat3";
        if (rst) begin
            chk({n, ".reset_outputs"}, 128'(o), '0);
            t[k] = -1;
            starve[k] = 0;
            for (int i = 0; i < 64; i++) smem[k][i] = init_word(k, i);
            return;
        end
        gp = 0; gd = 0; frc = 0; rd_done = 0; pdone = 0; e_prv = 0; e_drv = 0;
        if (t[k] < 0) begin
            frc     = FAIR && (starve[k] >= SMAX) && in.d_valid;
            gp      = in.p_req && !frc;
            gd      = !gp && in.d_valid;
            e_rdy   = gd;
            e_men   = 0;
            e_stall = in.p_req;
        end else begin
            rd_done = !rwe[k] && (t[k] == lat + 1);
            e_prv   = rd_done && !own_dma[k];
            e_drv   = rd_done && own_dma[k];
            pdone   = !own_dma[k] && ((rwe[k] && t[k] == 1) || rd_done);
            e_rdy   = 0;
            e_men   = (t[k] == 1);
            e_stall = in.p_req && !pdone;
        end
        chk({n, ".p_stall"}, o.p_stall, e_stall);
        chk({n, ".d_ready"}, o.d_ready, e_rdy);
        chk({n, ".m_en"}, o.m_en, e_men);
        chk({n, ".p_rvalid"}, o.p_rvalid, e_prv);
        chk({n, ".d_rvalid"}, o.d_rvalid, e_drv);
        if (e_men) begin
            chk({n, ".m_we"}, o.m_we, rwe[k]);
            chk({n, ".m_addr"}, o.m_addr, raddr[k]);
            if (rwe[k]) chk({n, ".m_wdata"}, o.m_wdata, rwdata[k]);
        end
        if (e_prv) chk({n, ".p_rdata"}, o.p_rdata, rexp[k]);
        if (e_drv) chk({n, ".d_rdata"}, o.d_rdata, rexp[k]);

        if (t[k] < 0) begin
            if (gp || gd) begin
                own_dma[k] = gd;
                rwe[k]     = gd ? in.d_we    : in.p_we;
                raddr[k]   = gd ? in.d_addr  : in.p_addr;
                rwdata[k]  = gd ? in.d_wdata : in.p_wdata;
                rexp[k]    = smem[k][raddr[k]];
                if (rwe[k]) smem[k][raddr[k]] = rwdata[k];
                if (gd) begin
                    starve[k] = 0;
                    dma_grants[k]++;
                end else begin
                    if (in.d_valid) starve[k]++;
                    pipe_grants[k]++;
                end
                t[k] = 1;
            end
        end else if ((rwe[k] && t[k] == 1) || rd_done) begin
            t[k] = -1;
        end else begin
            t[k]++;
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            model_step(0, LAT0, rst0, i0, o0);
            model_step(1, LAT1, rst1, i1, o1);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drv_p(input int k, input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] w);
        if (k == 0) begin
            bus0.p_req = req; bus0.p_we = we; bus0.p_addr = a; bus0.p_wdata = w;
        end else begin
            bus1.p_req = req; bus1.p_we = we; bus1.p_addr = a; bus1.p_wdata = w;
        end
    endtask

    task automatic drv_d(input int k, input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] w);
        if (k == 0) begin
            bus0.d_valid = v; bus0.d_we = we; bus0.d_addr = a; bus0.d_wdata = w;
        end else begin
            bus1.d_valid = v; bus1.d_we = we; bus1.d_addr = a; bus1.d_wdata = w;
        end
    endtask

    initial begin
        int nrdy, nrv, dbase, pbase;
        checks = 0;
        errors = 0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        drv_p(0, 0, 0, '0, '0); drv_d(0, 0, 0, '0, '0);
        drv_p(1, 0, 0, '0, '0); drv_d(1, 0, 0, '0, '0);
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        smp();
        chk("lit.reset_m_en", bus0.m_en, 0);
        chk("lit.reset_p_rvalid", bus1.p_rvalid, 0);
        cyc(); rst0 = 1'b0; rst1 = 1'b0;
        cyc();

        // Pipeline read of addr 5, MEM_LAT 1
        drv_p(0, 1, 0, 5, '0);
        smp(); chk("rd5.c0_stall", bus0.p_stall, 1); chk("rd5.c0_m_en", bus0.m_en, 0);
        cyc(); smp(); chk("rd5.c1_m_en", bus0.m_en, 1); chk("rd5.c1_m_addr", bus0.m_addr, 5);
        chk("rd5.c1_stall", bus0.p_stall, 1);
        cyc(); smp(); chk("rd5.c2_rvalid", bus0.p_rvalid, 1); chk("rd5.c2_rdata", bus0.p_rdata, 32'hDEADBEEF);
        chk("rd5.c2_stall", bus0.p_stall, 0);
        cyc(); drv_p(0, 0, 0, '0, '0);
        cyc();

        // Loader write of addr 3 with p_req low, then pipeline read-back
        drv_d(0, 1, 1, 3, 32'h12345678);
        smp(); chk("dw3.c0_d_ready", bus0.d_ready, 1);
        cyc(); drv_d(0, 0, 0, '0, '0);
        smp(); chk("dw3.c1_m_en", bus0.m_en, 1); chk("dw3.c1_m_we", bus0.m_we, 1);
        chk("dw3.c1_m_addr", bus0.m_addr, 3); chk("dw3.c1_m_wdata", bus0.m_wdata, 32'h12345678);
        cyc();
        drv_p(0, 1, 0, 3, '0);
        smp(); cyc(); smp(); cyc(); smp();
        chk("rb3.rvalid", bus0.p_rvalid, 1); chk("rb3.rdata", bus0.p_rdata, 32'h12345678);
        cyc(); drv_p(0, 0, 0, '0, '0);

        // Flush: p_req drops during ISSUE of a read; the access still completes
        cyc(); drv_p(0, 1, 0, 9, '0);
        cyc(); drv_p(0, 0, 0, '0, '0);
        repeat (3) cyc();

        // Back-to-back pipeline writes, then read back
        drv_p(0, 1, 1, 10, 32'hCAFE0010);
        repeat (4) cyc();
        drv_p(0, 0, 0, '0, '0);
        cyc();
        drv_p(0, 1, 0, 10, '0);
        repeat (3) cyc();
        drv_p(0, 0, 0, '0, '0);
        cyc();

        // Continuous contention, all writes: ten grants in twenty cycles
        dbase = dma_grants[0];
        pbase = pipe_grants[0];
        drv_p(0, 1, 1, 20, 32'h0000_0020);
        drv_d(0, 1, 1, 21, 32'h0000_0021);
        nrdy = 0;
        for (int c = 0; c < 20; c++) begin
            smp();
            if (bus0.d_ready) nrdy++;
            cyc();
        end
        drv_p(0, 0, 0, '0, '0);
        drv_d(0, 0, 0, '0, '0);
        chk("fair.d_ready_pulses", nrdy, FAIR ? 2 : 0);
        chk("fair.model_dma_grants", dma_grants[0] - dbase, FAIR ? 2 : 0);
        chk("fair.model_pipe_grants", pipe_grants[0] - pbase, FAIR ? 8 : 10);
        cyc();

        // Reset during WAIT of a MEM_LAT 3 read
        drv_p(1, 1, 0, 5, '0);
        smp(); chk("rst.c0_stall", bus1.p_stall, 1);
        cyc(); cyc();
        rst1 = 1'b1;
        drv_p(1, 0, 0, '0, '0);
        smp(); chk("rst.m_en", bus1.m_en, 0); chk("rst.p_rvalid", bus1.p_rvalid, 0);
        cyc(); rst1 = 1'b0;
        nrv = 0;
        for (int c = 0; c < 6; c++) begin
            smp();
            if (bus1.p_rvalid || bus1.d_rvalid) nrv++;
            cyc();
        end
        chk("rst.no_rvalid_after", nrv, 0);
        drv_p(1, 1, 1, 2, 32'h0000_0022);
        smp(); chk("rst.regrant_stall", bus1.p_stall, 1); chk("rst.regrant_m_en", bus1.m_en, 0);
        cyc(); smp(); chk("rst.regrant_issue", bus1.m_en, 1); chk("rst.regrant_we", bus1.m_we, 1);
        cyc(); drv_p(1, 0, 0, '0, '0);
        cyc();

        // MEM_LAT 3 loader read, pipeline read arriving during it
        drv_d(1, 1, 0, 5, '0);
        smp(); chk("l3.c0_d_ready", bus1.d_ready, 1);
        cyc(); drv_d(1, 0, 0, '0, '0); drv_p(1, 1, 0, 4, '0);
        smp(); chk("l3.c1_stall", bus1.p_stall, 1);
        for (int c = 2; c <= 4; c++) begin
            cyc(); smp();
            chk("l3.dma_phase_stall", bus1.p_stall, 1);
            chk("l3.d_rvalid_timing", bus1.d_rvalid, (c == 4) ? 1 : 0);
        end
        chk("l3.d_rdata", bus1.d_rdata, 32'hDEADBEEF);
        for (int c = 5; c <= 8; c++) begin
            cyc(); smp();
            chk("l3.pipe_phase_stall", bus1.p_stall, 1);
            chk("l3.p_rvalid_early", bus1.p_rvalid, 0);
        end
        cyc(); smp();
        chk("l3.c9_p_rvalid", bus1.p_rvalid, 1);
        chk("l3.c9_p_rdata", bus1.p_rdata, 32'hA501_0004);
        chk("l3.c9_stall", bus1.p_stall, 0);
        cyc(); drv_p(1, 0, 0, '0, '0);
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
